// File: rtl/ahb_rcc_divgen.sv
// AHB-Lite reset/clock-control slave: per-channel clock-enable dividers and stretched peripheral resets.
// Latency: zero-wait reads and writes, write commits at end of data phase; ERROR is a two-cycle response.
// Backpressure: HREADYOUT drops only in the first ERROR cycle; strobes and resets never stall.
`timescale 1ns/1ps
module ahb_rcc_divgen #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int RST_HOLD = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] periph_rstn_o
);

  localparam int              RW       = $clog2(RST_HOLD);
  localparam logic [RW-1:0]   RST_LAST = RW'(RST_HOLD - 1);
  localparam logic [9:0]      DIV_END  = 10'(NUM_CH + 4);

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} st_t;

  st_t               state;
  st_t               state_nx;

  logic [9:0]        a_word;
  logic              a_acc;
  logic              a_div;
  logic              a_map;
  logic              a_err;

  logic              dp_wr;
  logic              dp_rd;
  logic [9:0]        dp_word;

  logic              wr_clken;
  logic [NUM_CH-1:0] wr_div;
  logic [NUM_CH-1:0] wr_rst;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] rst_act;

  logic [DIV_W-1:0]  div_sh  [NUM_CH];
  logic [DIV_W-1:0]  div_act [NUM_CH];
  logic [DIV_W-1:0]  cnt     [NUM_CH];
  logic [RW-1:0]     rst_cnt [NUM_CH];

  logic [31:0]       status;
  logic              unused_ok;

  // Address-phase decode; word offset 3 (0x0C), misaligned and out-of-range offsets are unmapped.
  assign a_word = HADDR[11:2];
  assign a_acc  = HSEL && HREADY && HTRANS[1] && (state != ST_ERR1);
  assign a_div  = (a_word >= 10'd4) && (a_word < DIV_END);
  assign a_map  = (HADDR[1:0] == 2'b00) && ((a_word <= 10'd2) || a_div);
  assign a_err  = !a_map || (HSIZE != 3'b010) || (HWRITE && (a_word == 10'd2));

  assign unused_ok = ^{HADDR[31:12], HWDATA, HTRANS[0]};

  // Response state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_OK;
    else          state <= state_nx;
  end

  // Response sequencing: an erroring transfer holds HREADYOUT low one cycle, HRESP high for two.
  always_comb begin
    state_nx  = ST_OK;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
        if (a_acc && a_err) state_nx = ST_ERR1;
      end
      default: begin
        if (a_acc && a_err) state_nx = ST_ERR1;
      end
    endcase
  end

  // Data-phase capture; erroring transfers never reach the register file.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_wr   <= 1'b0;
      dp_rd   <= 1'b0;
      dp_word <= '0;
    end else begin
      dp_wr <= a_acc && !a_err && HWRITE;
      dp_rd <= a_acc && !a_err && !HWRITE;
      if (a_acc) dp_word <= a_word;
    end
  end

  // Per-channel write strobes and divider terminal count.
  always_comb begin
    wr_clken = dp_wr && (dp_word == 10'd0);
    wr_div   = '0;
    wr_rst   = '0;
    tc       = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      wr_div[n] = dp_wr && (dp_word == 10'(n + 4));
      wr_rst[n] = dp_wr && (dp_word == 10'd1) && HWDATA[n];
      tc[n]     = clken[n] && (cnt[n] == div_act[n]);
    end
  end

  assign clk_en_o      = tc;
  assign periph_rstn_o = ~rst_act;

  // Channel enable register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      clken <= '0;
    else if (wr_clken) clken <= HWDATA[NUM_CH-1:0];
  end

  // Dividers: shadow value is only promoted at a period boundary (or while stopped), so no short period.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int n = 0; n < NUM_CH; n++) begin
        cnt[n]     <= '0;
        div_act[n] <= '0;
        div_sh[n]  <= '0;
      end
      pend <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (!clken[n] || tc[n]) cnt[n] <= '0;
        else                    cnt[n] <= cnt[n] + DIV_W'(1);
        if (wr_div[n]) begin
          div_sh[n] <= HWDATA[DIV_W-1:0];
          pend[n]   <= 1'b1;
        end else if (pend[n] && (tc[n] || !clken[n])) begin
          div_act[n] <= div_sh[n];
          pend[n]    <= 1'b0;
        end
      end
    end
  end

  // Reset sequencers: hold each peripheral in reset for RST_HOLD cycles; a new request restarts the hold.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rst_act <= '1;
      for (int n = 0; n < NUM_CH; n++) rst_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_rst[n]) begin
          rst_act[n] <= 1'b1;
          rst_cnt[n] <= '0;
        end else if (rst_act[n]) begin
          if (rst_cnt[n] == RST_LAST) begin
            rst_act[n] <= 1'b0;
            rst_cnt[n] <= '0;
          end else begin
            rst_cnt[n] <= rst_cnt[n] + RW'(1);
          end
        end
      end
    end
  end

  // Status word: update-pending flags low, reset-active flags from bit 16.
  always_comb begin
    status               = '0;
    status[NUM_CH-1:0]   = pend;
    status[16 +: NUM_CH] = rst_act;
  end

  // Read mux, driven only during a read data phase.
  always_comb begin
    HRDATA = '0;
    if (dp_rd) begin
      if (dp_word == 10'd0)      HRDATA[NUM_CH-1:0] = clken;
      else if (dp_word == 10'd2) HRDATA = status;
      for (int n = 0; n < NUM_CH; n++) begin
        if (dp_word == 10'(n + 4)) HRDATA[DIV_W-1:0] = div_sh[n];
      end
    end
  end

endmodule
